// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle RV32M multiply/divide sequencer beside the execute ALU.
// Operands are captured as magnitudes on a start pulse. A 32-step shift-add multiply
// or restoring divide runs next, and the sign is applied in a single FIX cycle.
// Divide-by-zero and signed-overflow cases skip the iteration and finish in one cycle.
//
// state | meaning
// IDLE  | waiting for i_start; special-case divides resolved here
// CALC  | 32 iterations of shift-add multiply or restoring divide
// FIX   | sign correction and high/low word select
// DONE  | o_done pulse, o_result valid
module muldiv_seq (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_op_a,
    input  logic [31:0] i_op_b,
    input  logic        i_flush,
    output logic        o_busy,
    output logic        o_stall,
    output logic        o_done,
    output logic [31:0] o_result
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] a_q, a_d;            // |a|; dividend shifts out MSB-first during divide
    logic [31:0] b_q, b_d;            // |b|; multiplier shifts out LSB-first during multiply
    logic        neg_q, neg_d;
    logic [63:0] acc_q, acc_d;        // product, or remainder:quotient
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] result_q, result_d;

    // Operand decode for the launch cycle
    logic        a_signed, b_signed, a_neg, b_neg, is_div_in;
    logic [31:0] a_abs, b_abs;
    logic        div_zero, div_ovf, neg_in;
    logic [31:0] special_res;

    always_comb begin
        a_signed    = (i_funct3 == 3'b001) || (i_funct3 == 3'b010) ||
                      (i_funct3 == 3'b100) || (i_funct3 == 3'b110);
        b_signed    = (i_funct3 == 3'b001) || (i_funct3 == 3'b100) || (i_funct3 == 3'b110);
        a_neg       = a_signed & i_op_a[31];
        b_neg       = b_signed & i_op_b[31];
        a_abs       = a_neg ? (~i_op_a + 32'd1) : i_op_a;
        b_abs       = b_neg ? (~i_op_b + 32'd1) : i_op_b;
        is_div_in   = i_funct3[2];
        neg_in      = (is_div_in && i_funct3[1]) ? a_neg : (a_neg ^ b_neg);
        div_zero    = is_div_in && (i_op_b == 32'd0);
        div_ovf     = is_div_in && !i_funct3[0] &&
                      (i_op_a == 32'h8000_0000) && (i_op_b == 32'hFFFF_FFFF);
        special_res = 32'd0;
        if (div_zero)
            special_res = i_funct3[1] ? i_op_a : 32'hFFFF_FFFF;
        else if (div_ovf)
            special_res = i_funct3[1] ? 32'd0 : 32'h8000_0000;
    end

    // One iteration step and the final sign-fix result
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_rem_sh;
    logic [33:0] div_diff;
    logic [63:0] div_next;
    logic [63:0] mul_full;
    logic [31:0] mul_sel, div_val, div_sel, fix_res;

    always_comb begin
        mul_sum    = {1'b0, acc_q[63:32]} + {1'b0, (b_q[0] ? a_q : 32'd0)};
        mul_next   = {mul_sum, acc_q[31:1]};
        div_rem_sh = {acc_q[63:32], a_q[31]};
        div_diff   = {1'b0, div_rem_sh} - {2'b00, b_q};
        div_next   = div_diff[33] ? {div_rem_sh[31:0], acc_q[30:0], 1'b0}
                                  : {div_diff[31:0], acc_q[30:0], 1'b1};
        mul_full   = neg_q ? (~acc_q + 64'd1) : acc_q;
        mul_sel    = (funct3_q == 3'b000) ? mul_full[31:0] : mul_full[63:32];
        div_val    = funct3_q[1] ? acc_q[63:32] : acc_q[31:0];
        div_sel    = neg_q ? (~div_val + 32'd1) : div_val;
        fix_res    = funct3_q[2] ? div_sel : mul_sel;
    end

    // Next-state and datapath-register control
    always_comb begin
        state_d  = state_q;
        funct3_d = funct3_q;
        a_d      = a_q;
        b_d      = b_q;
        neg_d    = neg_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    funct3_d = i_funct3;
                    a_d      = a_abs;
                    b_d      = b_abs;
                    neg_d    = neg_in;
                    acc_d    = 64'd0;
                    cnt_d    = 5'd0;
                    if (div_zero || div_ovf) begin
                        result_d = special_res;
                        state_d  = S_DONE;
                    end else begin
                        state_d  = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (funct3_q[2]) begin
                    acc_d = div_next;
                    a_d   = {a_q[30:0], 1'b0};
                end else begin
                    acc_d = mul_next;
                    b_d   = {1'b0, b_q[31:1]};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31)
                    state_d = S_FIX;
            end
            S_FIX: begin
                result_d = fix_res;
                state_d  = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Flush wins over launch and completion; the published result is left alone.
        if (i_flush) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            funct3_q <= 3'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            neg_q    <= 1'b0;
            acc_q    <= 64'd0;
            cnt_q    <= 5'd0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            funct3_q <= funct3_d;
            a_q      <= a_d;
            b_q      <= b_d;
            neg_q    <= neg_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    // Status outputs; stall drops in DONE so the pipeline consumes the result on that edge
    always_comb begin
        o_busy   = (state_q != S_IDLE);
        o_done   = (state_q == S_DONE);
        o_stall  = ((state_q == S_IDLE) && i_start && !i_flush) ||
                   ((state_q != S_IDLE) && (state_q != S_DONE));
        o_result = result_q;
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed vectors plus hand-written flush/reset/back-to-back sequences.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b;
    logic        busy, stall, done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    muldiv_seq dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_start  (start),
        .i_funct3 (funct3),
        .i_op_a   (op_a),
        .i_op_b   (op_b),
        .i_flush  (flush),
        .o_busy   (busy),
        .o_stall  (stall),
        .o_done   (done),
        .o_result (result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Launch one op and wait for o_done; lat = cycle number (start edge = edge 0) of o_done.
    task automatic run_op(input string nm, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, output logic [31:0] res, output int lat);
        @(negedge clk);
        start = 1'b1; funct3 = f3; op_a = a; op_b = b;
        #1 chk({nm, "_stall_start"}, {31'd0, stall}, 32'd1);
        @(negedge clk);
        start = 1'b0; funct3 = 3'($urandom); op_a = $urandom; op_b = $urandom;
        lat = 1;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        res = result;
        chk({nm, "_stall_done"}, {31'd0, stall}, 32'd0);
    endtask

    logic [31:0] res, prev;
    int          lat, c1, c2, ndone;

    initial begin
        vecs[0]  = '{"mul_7x6",       3'b000, 32'd7,          32'd6,          32'h0000_002A, 34};
        vecs[1]  = '{"mulhu_max",     3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 34};
        vecs[2]  = '{"mulh_m1x2",     3'b001, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF, 34};
        vecs[3]  = '{"mulhsu_m1",     3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 34};
        vecs[4]  = '{"mul_m3x5",      3'b000, 32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFF1, 34};
        vecs[5]  = '{"div_m7_2",      3'b100, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD, 34};
        vecs[6]  = '{"rem_m7_2",      3'b110, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF, 34};
        vecs[7]  = '{"divu_100_7",    3'b101, 32'd100,        32'd7,          32'd14,        34};
        vecs[8]  = '{"remu_100_7",    3'b111, 32'd100,        32'd7,          32'd2,         34};
        vecs[9]  = '{"divu_5_0",      3'b101, 32'd5,          32'd0,          32'hFFFF_FFFF, 1};
        vecs[10] = '{"rem_5_0",       3'b110, 32'd5,          32'd0,          32'd5,         1};
        vecs[11] = '{"div_ovf",       3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 1};
        vecs[12] = '{"rem_ovf",       3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,         1};
        vecs[13] = '{"div_20_m3",     3'b100, 32'd20,         32'hFFFF_FFFD,  32'hFFFF_FFFA, 34};
        vecs[14] = '{"rem_20_m3",     3'b110, 32'd20,         32'hFFFF_FFFD,  32'd2,         34};
        vecs[15] = '{"mulh_min_sq",   3'b001, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000, 34};

        rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = 3'd0; op_a = 32'd0; op_b = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy",   {31'd0, busy},  32'd0);
        chk("rst_done",   {31'd0, done},  32'd0);
        chk("rst_stall",  {31'd0, stall}, 32'd0);
        chk("rst_result", result,         32'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_op(vecs[i].name, vecs[i].f3, vecs[i].a, vecs[i].b, res, lat);
            chk({vecs[i].name, "_result"}, res, vecs[i].exp);
            chk({vecs[i].name, "_latency"}, 32'(lat), 32'(vecs[i].lat));
            @(negedge clk);
            chk({vecs[i].name, "_idle_after"}, {31'd0, busy}, 32'd0);
        end

        // i_start during CALC must be ignored
        @(negedge clk);
        start = 1'b1; funct3 = 3'b000; op_a = 32'd7; op_b = 32'd6;
        @(negedge clk);
        start = 1'b0; lat = 1;
        while (!done && lat < 100) begin
            if (lat == 5) begin
                start = 1'b1; funct3 = 3'b101; op_a = 32'd100; op_b = 32'd7;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        chk("calc_start_result",  result,   32'h0000_002A);
        chk("calc_start_latency", 32'(lat), 32'd34);
        @(negedge clk);
        chk("calc_start_idle", {31'd0, busy}, 32'd0);

        // Back-to-back MUL ops complete 35 cycles apart
        run_op("b2b_1", 3'b000, 32'd3, 32'd4, res, lat);
        c1 = cyc;
        chk("b2b_1_result", res, 32'd12);
        run_op("b2b_2", 3'b000, 32'd5, 32'd5, res, lat);
        c2 = cyc;
        chk("b2b_2_result", res, 32'd25);
        chk("b2b_gap", 32'(c2 - c1), 32'd35);

        // Flush in cycle 10 of a DIV
        @(negedge clk);
        prev = result;
        start = 1'b1; funct3 = 3'b100; op_a = 32'd1000; op_b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy",   {31'd0, busy},  32'd0);
        chk("flush_done",   {31'd0, done},  32'd0);
        chk("flush_result", result,         prev);
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("flush_no_done", 32'(ndone), 32'd0);

        // i_start with i_flush in IDLE: no launch
        start = 1'b1; flush = 1'b1; funct3 = 3'b000; op_a = 32'd9; op_b = 32'd9;
        #1 chk("startflush_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("startflush_busy", {31'd0, busy}, 32'd0);

        // Reset in cycle 20 of a MUL
        @(negedge clk);
        start = 1'b1; funct3 = 3'b000; op_a = 32'd11; op_b = 32'd13;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        chk("midrst_busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy",   {31'd0, busy},  32'd0);
        chk("midrst_done",   {31'd0, done},  32'd0);
        chk("midrst_stall",  {31'd0, stall}, 32'd0);
        chk("midrst_result", result,         32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
